cache_miss_handler: RTL and testbench

- Miss-service stage directly downstream of the set-associative tag/data lookup.
- On a lookup miss it accepts the miss request and the chosen victim line.
- If the victim is dirty, it writes the victim back to main memory, then fetches the missing 64-bit line as 8 byte beats.
- It merges a pending store byte, returns a fill (tag, valid, dirty, data) to the lookup stage's arrays, and returns the requested byte to the requester.

---
 rtl/cache_pkg.sv | 50 +++++
 rtl/line_byte_buffer.sv | 44 ++++
 rtl/cache_miss_handler.sv | 215 +++++++++++++++++++++
 tb/tb_cache_miss_handler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
// Module  : cache_pkg
// Purpose : Shared widths, FSM state encoding and address helpers for the
//           cache miss-service stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  localparam int ADDR_W     = 32;
  localparam int OFFSET_W   = 3;
  localparam int INDEX_W    = 2;
  localparam int WAYS       = 4;
  localparam int WAY_W      = $clog2(WAYS);
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_DATA = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    FILL    = 3'd5,
    RESP    = 3'd6
  } miss_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
    return addr_fields_t'(addr);
  endfunction

  function automatic logic [63:0] set_byte(input logic [63:0] line,
                                           input logic [OFFSET_W-1:0] idx,
                                           input logic [7:0] b);
    logic [63:0] res;
    res = line;
    res[{idx, 3'b000} +: 8] = b;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_byte_buffer.sv
// ============================================================================
// Module  : line_byte_buffer
// Purpose : 8x8 byte register file with indexed byte write/read plus a
//           parallel 64-bit load and 64-bit view of the whole line.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module line_byte_buffer
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic [63:0]         load_data,
  input  logic                wr_en,
  input  logic [OFFSET_W-1:0] wr_idx,
  input  logic [7:0]          wr_data,
  input  logic [OFFSET_W-1:0] rd_idx,
  output logic [7:0]          rd_data,
  output logic [63:0]         line
);

  logic [7:0] r_bytes [LINE_BYTES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_BYTES; i++) r_bytes[i] <= 8'h00;
    end else if (load_en) begin
      for (int i = 0; i < LINE_BYTES; i++) r_bytes[i] <= load_data[8*i +: 8];
    end else if (wr_en) begin
      r_bytes[wr_idx] <= wr_data;
    end
  end

  assign rd_data = r_bytes[rd_idx];

  for (genvar g = 0; g < LINE_BYTES; g++) begin : g_view
    assign line[8*g +: 8] = r_bytes[g];
  end

endmodule

`default_nettype wire

// File: rtl/cache_miss_handler.sv
// ============================================================================
// Module  : cache_miss_handler
// Purpose : Services a lookup miss: optional dirty-victim writeback, 8-beat
//           line refill, store-byte merge, array fill and requester response.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_miss_handler
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [ADDR_W-1:0]  miss_addr,
  input  logic               miss_is_write,
  input  logic [7:0]         miss_wdata,
  input  logic [WAY_W-1:0]   victim_way,
  input  logic               victim_valid,
  input  logic               victim_dirty,
  input  logic [TAG_W-1:0]   victim_tag,
  input  logic [63:0]        victim_data,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_write,
  output logic [ADDR_W-1:0]  mem_req_addr,
  output logic               mem_wvalid,
  input  logic               mem_wready,
  output logic [7:0]         mem_wdata,
  input  logic               mem_rvalid,
  input  logic [7:0]         mem_rdata,
  output logic               fill_valid,
  output logic [INDEX_W-1:0] fill_index,
  output logic [WAY_W-1:0]   fill_way,
  output logic [TAG_W-1:0]   fill_tag,
  output logic               fill_dirty,
  output logic [63:0]        fill_data,
  output logic               resp_valid,
  output logic [7:0]         resp_data,
  output logic               busy
);

  miss_state_t         r_state;
  logic [OFFSET_W-1:0] r_cnt;
  logic [TAG_W-1:0]    r_tag;
  logic [INDEX_W-1:0]  r_index;
  logic [OFFSET_W-1:0] r_offset;
  logic [WAY_W-1:0]    r_way;
  logic                r_is_write;
  logic [7:0]          r_wdata;

  addr_fields_t        w_miss;
  logic                w_accept;
  logic                w_refill_wr;
  logic [OFFSET_W-1:0] w_victim_idx;
  logic [7:0]          w_victim_rd;
  logic [7:0]          w_refill_rd;
  logic [63:0]         w_victim_line;
  logic [63:0]         w_refill_line;
  logic [63:0]         w_beat7_line;
  logic [63:0]         w_fill_line;

  assign w_miss       = split_addr(miss_addr);
  assign w_accept     = (r_state == IDLE) && miss_valid;
  assign w_refill_wr  = (r_state == RD_DATA) && mem_rvalid;
  assign w_victim_idx = r_cnt + 3'd1;

  // The final beat is still in flight when the fill is registered, so fold it in here.
  assign w_beat7_line = set_byte(w_refill_line, 3'd7, mem_rdata);
  assign w_fill_line  = r_is_write ? set_byte(w_beat7_line, r_offset, r_wdata) : w_beat7_line;

  line_byte_buffer u_victim_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (w_accept),
    .load_data (victim_data),
    .wr_en     (1'b0),
    .wr_idx    (3'd0),
    .wr_data   (8'h00),
    .rd_idx    (w_victim_idx),
    .rd_data   (w_victim_rd),
    .line      (w_victim_line)
  );

  line_byte_buffer u_refill_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (1'b0),
    .load_data (64'h0),
    .wr_en     (w_refill_wr),
    .wr_idx    (r_cnt),
    .wr_data   (mem_rdata),
    .rd_idx    (r_offset),
    .rd_data   (w_refill_rd),
    .line      (w_refill_line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_tag         <= '0;
      r_index       <= '0;
      r_offset      <= '0;
      r_way         <= '0;
      r_is_write    <= 1'b0;
      r_wdata       <= 8'h00;
      miss_ready    <= 1'b1;
      busy          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_wvalid    <= 1'b0;
      mem_wdata     <= 8'h00;
      fill_valid    <= 1'b0;
      fill_index    <= '0;
      fill_way      <= '0;
      fill_tag      <= '0;
      fill_dirty    <= 1'b0;
      fill_data     <= 64'h0;
      resp_valid    <= 1'b0;
      resp_data     <= 8'h00;
    end else begin
      fill_valid <= 1'b0;
      resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (miss_valid) begin
            r_tag         <= w_miss.tag;
            r_index       <= w_miss.index;
            r_offset      <= w_miss.offset;
            r_way         <= victim_way;
            r_is_write    <= miss_is_write;
            r_wdata       <= miss_wdata;
            miss_ready    <= 1'b0;
            busy          <= 1'b1;
            mem_req_valid <= 1'b1;
            if (victim_valid && victim_dirty) begin
              r_state       <= WB_REQ;
              mem_req_write <= 1'b1;
              mem_req_addr  <= {victim_tag, w_miss.index, 3'b000};
            end else begin
              r_state       <= RD_REQ;
              mem_req_write <= 1'b0;
              mem_req_addr  <= {w_miss.tag, w_miss.index, 3'b000};
            end
          end
        end
        WB_REQ: begin
          if (mem_req_ready) begin
            r_state       <= WB_DATA;
            r_cnt         <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_wvalid    <= 1'b1;
            mem_wdata     <= w_victim_line[7:0];
          end
        end
        WB_DATA: begin
          if (mem_wready) begin
            if (r_cnt == 3'd7) begin
              r_state       <= RD_REQ;
              r_cnt         <= '0;
              mem_wvalid    <= 1'b0;
              mem_req_valid <= 1'b1;
              mem_req_write <= 1'b0;
              mem_req_addr  <= {r_tag, r_index, 3'b000};
            end else begin
              r_cnt     <= r_cnt + 3'd1;
              mem_wdata <= w_victim_rd;
            end
          end
        end
        RD_REQ: begin
          if (mem_req_ready) begin
            r_state       <= RD_DATA;
            r_cnt         <= '0;
            mem_req_valid <= 1'b0;
          end
        end
        RD_DATA: begin
          if (mem_rvalid) begin
            if (r_cnt == 3'd7) begin
              r_state    <= FILL;
              r_cnt      <= '0;
              fill_valid <= 1'b1;
              fill_index <= r_index;
              fill_way   <= r_way;
              fill_tag   <= r_tag;
              fill_dirty <= r_is_write;
              fill_data  <= w_fill_line;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        FILL: begin
          r_state    <= RESP;
          resp_valid <= 1'b1;
          resp_data  <= r_is_write ? r_wdata : w_refill_rd;
        end
        RESP: begin
          r_state    <= IDLE;
          busy       <= 1'b0;
          miss_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_miss_handler.sv
// ============================================================================
// Module  : tb_cache_miss_handler
// Purpose : Directed self-checking bench for cache_miss_handler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_miss_handler;
  import cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               miss_valid, miss_ready, miss_is_write;
  logic [ADDR_W-1:0]  miss_addr;
  logic [7:0]         miss_wdata;
  logic [WAY_W-1:0]   victim_way;
  logic               victim_valid, victim_dirty;
  logic [TAG_W-1:0]   victim_tag;
  logic [63:0]        victim_data;
  logic               mem_req_valid, mem_req_ready, mem_req_write;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_wvalid, mem_wready;
  logic [7:0]         mem_wdata;
  logic               mem_rvalid;
  logic [7:0]         mem_rdata;
  logic               fill_valid, fill_dirty;
  logic [INDEX_W-1:0] fill_index;
  logic [WAY_W-1:0]   fill_way;
  logic [TAG_W-1:0]   fill_tag;
  logic [63:0]        fill_data;
  logic               resp_valid;
  logic [7:0]         resp_data;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  bit chk_busy = 1'b0;

  always #5 clk = ~clk;

  cache_miss_handler dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_is_write(miss_is_write), .miss_wdata(miss_wdata),
    .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_data(victim_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_dirty(fill_dirty), .fill_data(fill_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (chk_busy) begin
      chk("b2b_ready_low", miss_ready, 1'b0);
      chk("b2b_busy_high", busy, 1'b1);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_miss_ready"}, miss_ready, 1'b1);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_req_valid"}, mem_req_valid, 1'b0);
    chk({nm, "_req_write"}, mem_req_write, 1'b0);
    chk({nm, "_req_addr"}, mem_req_addr, 32'h0);
    chk({nm, "_wvalid"}, mem_wvalid, 1'b0);
    chk({nm, "_wdata"}, mem_wdata, 8'h0);
    chk({nm, "_fill_valid"}, fill_valid, 1'b0);
    chk({nm, "_fill_dirty"}, fill_dirty, 1'b0);
    chk({nm, "_fill_fields"}, {fill_index, fill_way, fill_tag}, 64'h0);
    chk({nm, "_fill_data"}, fill_data, 64'h0);
    chk({nm, "_resp_valid"}, resp_valid, 1'b0);
    chk({nm, "_resp_data"}, resp_data, 8'h0);
  endtask

  task automatic present(input string nm, input logic [31:0] addr, input logic wr,
                         input logic [7:0] wd, input logic [1:0] way, input logic vv,
                         input logic vd, input logic [26:0] vtag, input logic [63:0] vdata,
                         input bit hold);
    t0 = cyc;
    miss_valid = 1'b1; miss_addr = addr; miss_is_write = wr; miss_wdata = wd;
    victim_way = way; victim_valid = vv; victim_dirty = vd; victim_tag = vtag;
    victim_data = vdata;
    tick();
    if (!hold) miss_valid = 1'b0;
    chk({nm, "_accept_ready"}, miss_ready, 1'b0);
    chk({nm, "_accept_busy"}, busy, 1'b1);
  endtask

  task automatic do_req(input string nm, input logic wr, input logic [31:0] addr, input int stall);
    int g = 0;
    while (!mem_req_valid && g < 20) begin
      tick();
      g++;
    end
    chk({nm, "_req_seen"}, mem_req_valid, 1'b1);
    for (int s = 0; s < stall; s++) begin
      chk({nm, "_req_write_hold"}, mem_req_write, wr);
      chk({nm, "_req_addr_hold"}, mem_req_addr, addr);
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b1;
      mem_rdata     = 8'hEE;
      tick();
    end
    mem_rvalid = 1'b0;
    chk({nm, "_req_write"}, mem_req_write, wr);
    chk({nm, "_req_addr"}, mem_req_addr, addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk({nm, "_req_drop"}, mem_req_valid, 1'b0);
  endtask

  task automatic do_wb(input string nm, input logic [63:0] line, input bit toggle);
    int  n = 0;
    int  g = 0;
    logic acc;
    while (mem_wvalid && g < 40) begin
      chk({nm, "_wdata"}, mem_wdata, 8'(line >> (8 * n)));
      acc = toggle ? logic'(g % 2 == 1) : 1'b1;
      mem_wready = acc;
      tick();
      if (acc) n++;
      g++;
    end
    mem_wready = 1'b0;
    chk({nm, "_wb_beats"}, n, 8);
  endtask

  task automatic do_rd(input logic [63:0] line, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && (i % 3 == 1)) begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'hCC;
        tick();
        tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 8'(line >> (8 * i));
      tick();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic finish_miss(input string nm, input logic [1:0] idx, input logic [1:0] way,
                             input logic [26:0] tag, input logic dirty, input logic [63:0] data,
                             input logic [7:0] rdata, input int lat);
    chk({nm, "_fill_valid"}, fill_valid, 1'b1);
    chk({nm, "_fill_index"}, fill_index, idx);
    chk({nm, "_fill_way"}, fill_way, way);
    chk({nm, "_fill_tag"}, fill_tag, tag);
    chk({nm, "_fill_dirty"}, fill_dirty, dirty);
    chk({nm, "_fill_data"}, fill_data, data);
    chk({nm, "_fill_resp_early"}, resp_valid, 1'b0);
    tick();
    chk({nm, "_resp_valid"}, resp_valid, 1'b1);
    chk({nm, "_resp_data"}, resp_data, rdata);
    chk({nm, "_fill_pulse"}, fill_valid, 1'b0);
    if (lat > 0) chk({nm, "_latency"}, cyc - t0, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    miss_valid = 1'b0; miss_addr = '0; miss_is_write = 1'b0; miss_wdata = 8'h0;
    victim_way = '0; victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0;
    victim_data = 64'h0; mem_req_ready = 1'b0; mem_wready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 8'h0;
    tick();
    tick();
    chk_reset("rst_hold");
    rst = 1'b0;
    tick();
    chk_reset("rst_idle");

    // Clean read miss
    present("clean", 32'h0000_0123, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 27'h7, 64'hDEAD_BEEF_0000_0000, 1'b0);
    do_req("clean", 1'b0, 32'h0000_0120, 0);
    do_rd(64'h1716_1514_1312_1110, 1'b0);
    finish_miss("clean", 2'd0, 2'd2, 27'h9, 1'b0, 64'h1716_1514_1312_1110, 8'h13, 11);
    tick();

    // Store miss, victim invalid but dirty -> no writeback
    present("store", 32'h0000_001D, 1'b1, 8'hAB, 2'd3, 1'b0, 1'b1, 27'h3, 64'h1111_1111_1111_1111, 1'b0);
    do_req("store", 1'b0, 32'h0000_0018, 0);
    do_rd(64'h1716_1514_1312_1110, 1'b0);
    finish_miss("store", 2'd3, 2'd3, 27'h0, 1'b1, 64'h1716_AB14_1312_1110, 8'hAB, 11);
    tick();

    // Dirty victim writeback then refill
    present("dirty", 32'h0000_104A, 1'b0, 8'h00, 2'd1, 1'b1, 1'b1, 27'h15, 64'h8877_6655_4433_2211, 1'b0);
    do_req("dirty_wb", 1'b1, 32'h0000_02A8, 0);
    do_wb("dirty", 64'h8877_6655_4433_2211, 1'b0);
    do_req("dirty_rd", 1'b0, 32'h0000_1048, 0);
    do_rd(64'h3736_3534_3332_3130, 1'b0);
    finish_miss("dirty", 2'd1, 2'd1, 27'h82, 1'b0, 64'h3736_3534_3332_3130, 8'h32, 20);
    tick();

    // Backpressure on every channel, store merge at offset 7
    present("bp", 32'h0000_0FF7, 1'b1, 8'h5A, 2'd0, 1'b1, 1'b1, 27'h1, 64'h0123_4567_89AB_CDEF, 1'b0);
    do_req("bp_wb", 1'b1, 32'h0000_0030, 3);
    do_wb("bp", 64'h0123_4567_89AB_CDEF, 1'b1);
    do_req("bp_rd", 1'b0, 32'h0000_0FF0, 3);
    do_rd(64'hA7A6_A5A4_A3A2_A1A0, 1'b1);
    finish_miss("bp", 2'd2, 2'd0, 27'h7F, 1'b1, 64'h5AA6_A5A4_A3A2_A1A0, 8'h5A, 0);
    tick();

    // Reset during read beat 4
    present("abort", 32'h0000_0123, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 27'h0, 64'h0, 1'b0);
    do_req("abort", 1'b0, 32'h0000_0120, 0);
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 8'h40 + 8'(i);
      tick();
    end
    mem_rdata = 8'h44;
    rst = 1'b1;
    #1;
    chk_reset("abort_async");
    mem_rvalid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_fill", fill_valid, 1'b0);
      chk("abort_no_resp", resp_valid, 1'b0);
    end
    present("post", 32'h0000_0318, 1'b0, 8'h00, 2'd3, 1'b1, 1'b0, 27'h2, 64'h0, 1'b0);
    do_req("post", 1'b0, 32'h0000_0318, 0);
    do_rd(64'h6766_6564_6362_6160, 1'b0);
    finish_miss("post", 2'd3, 2'd3, 27'h18, 1'b0, 64'h6766_6564_6362_6160, 8'h60, 11);
    tick();

    // Back-to-back misses with miss_valid held high
    present("b2b1", 32'h0000_0123, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 27'h0, 64'h0, 1'b1);
    chk_busy = 1'b1;
    do_req("b2b1", 1'b0, 32'h0000_0120, 0);
    do_rd(64'h2726_2524_2322_2120, 1'b0);
    finish_miss("b2b1", 2'd0, 2'd0, 27'h9, 1'b0, 64'h2726_2524_2322_2120, 8'h23, 11);
    chk_busy = 1'b0;
    tick();
    chk("b2b_idle_ready", miss_ready, 1'b1);
    chk("b2b_idle_busy", busy, 1'b0);
    chk("b2b_idle_req", mem_req_valid, 1'b0);
    t0 = cyc;
    tick();
    miss_valid = 1'b0;
    chk("b2b2_accept_ready", miss_ready, 1'b0);
    chk("b2b2_accept_req", mem_req_valid, 1'b1);
    do_req("b2b2", 1'b0, 32'h0000_0120, 0);
    do_rd(64'h5756_5554_5352_5150, 1'b0);
    finish_miss("b2b2", 2'd0, 2'd0, 27'h9, 1'b0, 64'h5756_5554_5352_5150, 8'h53, 11);
    tick();
    chk("final_ready", miss_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
